// File: rtl/io_uart_tx.sv
// Transmit-only 8N1 UART fed by single-cycle IO write strobes.
// Bytes queue in a small FIFO and are sent LSB first on a registered TXD line.
module io_uart_tx #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               TX_WE,
    input  logic [7:0]         TX_WD,
    input  logic               OVR_CLR,
    output logic               TX_FULL,
    output logic               TX_BUSY,
    output logic [FIFO_AW:0]   TX_LEVEL,
    output logic               OVERRUN,
    output logic               TXD
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW    = $clog2(CLK_DIV);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] LVL_EMPTY = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             ovr_q, ovr_d;
    state_t           state_q;
    logic [BW-1:0]    baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic             txd_q;

    logic [FIFO_AW:0] level_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             baud_tc_s;
    logic [7:0]       head_s;

    assign level_s   = wr_ptr_q - rd_ptr_q;
    assign empty_s   = (level_s == LVL_EMPTY);
    assign full_s    = (level_s == LVL_FULL);
    assign push_s    = TX_WE & ~full_s;
    assign baud_tc_s = (baud_q == BAUD_LAST);
    assign head_s    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign TX_FULL  = full_s;
    assign TX_LEVEL = level_s;
    assign TX_BUSY  = (state_q != S_IDLE) | ~empty_s;
    assign OVERRUN  = ovr_q;
    assign TXD      = txd_q;

    // FSM consumes the FIFO head when idle, or straight out of a stop bit.
    always_comb begin
        pop_s = 1'b0;
        if (empty_s) begin
            pop_s = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  pop_s = 1'b1;
                S_STOP:  pop_s = baud_tc_s;
                default: pop_s = 1'b0;
            endcase
        end
    end

    // Pointer and sticky overrun next-state; a new overrun beats a clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovr_d    = ovr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (TX_WE && full_s) begin
            ovr_d = 1'b1;
        end else if (OVR_CLR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // FIFO storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= TX_WD;
        end
    end

    // FIFO pointers and overrun flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= LVL_EMPTY;
            rd_ptr_q <= LVL_EMPTY;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    // Serialiser FSM: start, eight data bits LSB first, stop; TXD registered.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty_s) begin
                        sh_q    <= head_s;
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                        baud_q  <= {BW{1'b0}};
                    end else begin
                        txd_q   <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_tc_s) begin
                        state_q <= S_DATA;
                        txd_q   <= sh_q[0];
                        bit_q   <= 3'd0;
                        baud_q  <= {BW{1'b0}};
                    end else begin
                        baud_q  <= baud_q + BW'(1'b1);
                    end
                end
                S_DATA: begin
                    if (baud_tc_s) begin
                        baud_q <= {BW{1'b0}};
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            sh_q  <= {1'b0, sh_q[7:1]};
                            bit_q <= bit_q + 3'd1;
                            txd_q <= sh_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1'b1);
                    end
                end
                S_STOP: begin
                    if (baud_tc_s) begin
                        baud_q <= {BW{1'b0}};
                        if (!empty_s) begin
                            sh_q    <= head_s;
                            state_q <= S_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1'b1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= {BW{1'b0}};
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx at CLK_DIV=4, FIFO_AW=3; a queue of written
// bytes is checked against each frame recovered from TXD.
module tb_io_uart_tx;

    localparam int DIV = 4;
    localparam int AW  = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          TX_WE = 1'b0;
    logic [7:0]    TX_WD = 8'h00;
    logic          OVR_CLR = 1'b0;
    logic          TX_FULL;
    logic          TX_BUSY;
    logic [AW:0]   TX_LEVEL;
    logic          OVERRUN;
    logic          TXD;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    exp_q[$];

    io_uart_tx #(.CLK_DIV(DIV), .FIFO_AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .TX_WE(TX_WE), .TX_WD(TX_WD), .OVR_CLR(OVR_CLR),
        .TX_FULL(TX_FULL), .TX_BUSY(TX_BUSY), .TX_LEVEL(TX_LEVEL),
        .OVERRUN(OVERRUN), .TXD(TXD)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe; the byte joins the scoreboard only if the bench expects it kept.
    task automatic wr(input logic [7:0] d, input bit acc);
        TX_WE = 1'b1;
        TX_WD = d;
        if (acc) exp_q.push_back(d);
        @(negedge CLK);
        TX_WE = 1'b0;
    endtask

    // Samples TXD now and at each falling edge; lat = idle samples before the start bit.
    task automatic rx_frame(input int lat, output logic [AW:0] lvl);
        int         w;
        logic [7:0] b;
        logic [7:0] e;
        logic       bad;
        w = 0; b = 8'h00; bad = 1'b0; e = 8'h00;
        while (TXD !== 1'b0 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        chk("rx_timeout", (w < 200) ? 32'd1 : 32'd0, 32'd1);
        chk("start_latency", w, lat);
        chk("busy_in_frame", TX_BUSY, 1'b1);
        lvl = TX_LEVEL;
        for (int j = 0; j < DIV - 1; j++) begin
            @(negedge CLK);
            if (TXD !== 1'b0) bad = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < DIV; j++) begin
                @(negedge CLK);
                if (j == 0) b[i] = TXD;
                else if (TXD !== b[i]) bad = 1'b1;
            end
        end
        for (int j = 0; j < DIV; j++) begin
            @(negedge CLK);
            if (TXD !== 1'b1) bad = 1'b1;
        end
        chk("frame_shape", bad, 1'b0);
        chk("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("rx_byte", b, e);
    endtask

    initial begin
        logic [AW:0] lvl;
        logic        bad;

        // Reset held: a write must be ignored.
        repeat (2) @(negedge CLK);
        wr(8'hA5, 1'b0);
        chk("rst_txd", TXD, 1'b1);
        chk("rst_level", TX_LEVEL, 4'd0);
        chk("rst_busy", TX_BUSY, 1'b0);
        chk("rst_full", TX_FULL, 1'b0);
        chk("rst_ovr", OVERRUN, 1'b0);
        RESET = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (TXD !== 1'b1) bad = 1'b1;
        end
        chk("rst_no_tx", bad, 1'b0);
        chk("rst_level_after", TX_LEVEL, 4'd0);

        // Single byte.
        wr(8'h5A, 1'b1);
        chk("single_level", TX_LEVEL, 4'd1);
        rx_frame(1, lvl);
        chk("single_lvl_start", lvl, 4'd0);
        @(negedge CLK);
        chk("single_busy_end", TX_BUSY, 1'b0);
        chk("single_txd_end", TXD, 1'b1);

        // Back-to-back: the second byte is pushed as the first is popped.
        wr(8'h01, 1'b1);
        chk("b2b_level1", TX_LEVEL, 4'd1);
        wr(8'hFF, 1'b1);
        rx_frame(0, lvl);
        chk("b2b_level2", lvl, 4'd1);
        rx_frame(1, lvl);
        chk("b2b_level3", lvl, 4'd0);
        @(negedge CLK);
        chk("b2b_busy_end", TX_BUSY, 1'b0);

        // Ten consecutive writes: nine kept, the tenth overruns.
        fork
            begin
                for (int i = 0; i < 10; i++) wr(8'hC0 + 8'(i), (i < 9));
                chk("full_level", TX_LEVEL, 4'd8);
                chk("full_flag", TX_FULL, 1'b1);
                chk("ovr_set", OVERRUN, 1'b1);
                TX_WE = 1'b1; TX_WD = 8'hEE; OVR_CLR = 1'b1;
                @(negedge CLK);
                TX_WE = 1'b0; OVR_CLR = 1'b0;
                chk("ovr_set_wins", OVERRUN, 1'b1);
                chk("full_level_hold", TX_LEVEL, 4'd8);
                OVR_CLR = 1'b1;
                @(negedge CLK);
                OVR_CLR = 1'b0;
                chk("ovr_clear", OVERRUN, 1'b0);
            end
            begin
                rx_frame(2, lvl);
                for (int k = 0; k < 8; k++) rx_frame(1, lvl);
            end
        join
        @(negedge CLK);
        chk("full_drain_level", TX_LEVEL, 4'd0);
        chk("full_drain_busy", TX_BUSY, 1'b0);

        // Reset during data bit 3 of 0xA5 with a second byte still queued.
        wr(8'hA5, 1'b1);
        wr(8'h3C, 1'b1);
        repeat (16) @(negedge CLK);
        chk("mid_bit3", TXD, 1'b0);
        RESET = 1'b0;
        #1;
        chk("mid_rst_txd", TXD, 1'b1);
        chk("mid_rst_level", TX_LEVEL, 4'd0);
        chk("mid_rst_busy", TX_BUSY, 1'b0);
        exp_q.delete();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        wr(8'h33, 1'b1);
        rx_frame(1, lvl);
        @(negedge CLK);
        chk("post_rst_busy", TX_BUSY, 1'b0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
